// File: rtl/pwm_fade_pkg.sv
// Shared types and default widths for the pwm fade sequencer.
package pwm_fade_pkg;

    localparam int unsigned DEF_CTR_LEN = 8;
    localparam int unsigned DEF_HOLD_W  = 8;
    localparam int unsigned DEF_CYC_W   = 8;

    // Sequencer states: idle, ramping up, ramping down, waiting for the boundary to park at 0
    typedef enum logic [1:0] {
        StIdle,
        StRise,
        StFall,
        StDrain
    } state_e;

endpackage

// File: rtl/pwm_fade_ctrl_pwm.sv
// Basic PWM: free-running counter, output high while counter < compare.
// The output is registered, so it is a clean flop output. The high window is shifted one
// clk behind the counter, but the duty per period is exactly compare clks.
module pwm_fade_ctrl_pwm #(
    parameter int unsigned CTR_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CTR_LEN-1:0] compare,
    output logic               pwm
);

    logic [CTR_LEN-1:0] cnt;

    // Free-running period counter; shares rst with the sequencer's counter so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CTR_LEN'(1);
        end
    end

    // Registered duty comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < compare);
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// LED fade sequencer: ramps the compare value of one pwm instance between lo and hi levels.
// The compare register only changes on the last clk of a period, so every period runs at
// a single duty and the output never glitches mid-period.
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int unsigned CTR_LEN = DEF_CTR_LEN,
    parameter int unsigned HOLD_W  = DEF_HOLD_W,
    parameter int unsigned CYC_W   = DEF_CYC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [CTR_LEN-1:0] lo_level,
    input  logic [CTR_LEN-1:0] hi_level,
    input  logic [CTR_LEN-1:0] step,
    input  logic [HOLD_W-1:0]  hold,
    input  logic [CYC_W-1:0]   cycles,
    output logic [CTR_LEN-1:0] compare,
    output logic               pwm,
    output logic               period_tick,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [CTR_LEN-1:0] CTR_MAX = '1;

    state_e             state;
    logic [CTR_LEN-1:0] ctr;
    logic [CTR_LEN-1:0] level;

    // Configuration captured on an accepted start
    logic [CTR_LEN-1:0] lo_q;
    logic [CTR_LEN-1:0] hi_q;
    logic [CTR_LEN-1:0] step_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [CYC_W-1:0]   cycles_q;

    logic [HOLD_W-1:0]  hold_cnt;
    logic [CYC_W-1:0]   cyc_cnt;

    logic [CTR_LEN:0]   sum_up;
    logic [CTR_LEN:0]   diff_dn;
    logic [CTR_LEN-1:0] level_up;
    logic [CTR_LEN-1:0] level_dn;
    logic               hold_hit;
    logic [CYC_W-1:0]   cyc_next;
    logic               last_cycle;
    logic               cfg_ok;

    // Period counter, kept in lockstep with the pwm instance's own counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr <= '0;
        end else begin
            ctr <= ctr + CTR_LEN'(1);
        end
    end

    assign period_tick = (ctr == CTR_MAX);

    // Level arithmetic: one extra bit so the up-step can saturate at hi instead of wrapping,
    // and the sign bit of the down-step catches underflow below zero before clamping at lo
    always_comb begin
        sum_up   = {1'b0, level} + {1'b0, step_q};
        diff_dn  = {1'b0, level} - {1'b0, step_q};
        level_up = (sum_up > {1'b0, hi_q}) ? hi_q : sum_up[CTR_LEN-1:0];
        if (diff_dn[CTR_LEN] || (diff_dn[CTR_LEN-1:0] < lo_q)) begin
            level_dn = lo_q;
        end else begin
            level_dn = diff_dn[CTR_LEN-1:0];
        end
        hold_hit   = (hold_cnt == hold_q);
        cyc_next   = cyc_cnt + CYC_W'(1);
        last_cycle = (cycles_q != '0) && (cyc_next == cycles_q);
        cfg_ok     = (lo_level <= hi_level);
    end

    // Sequencer FSM with registered compare/busy/done/cfg_err
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            compare  <= '0;
            level    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            cycles_q <= '0;
            hold_cnt <= '0;
            cyc_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (period_tick) begin
                        compare <= '0;
                    end
                    // A simultaneous stop drops the start outright, including the level check
                    if (start && !stop) begin
                        if (cfg_ok) begin
                            lo_q     <= lo_level;
                            hi_q     <= hi_level;
                            step_q   <= step;
                            hold_q   <= hold;
                            cycles_q <= cycles;
                            level    <= lo_level;
                            hold_cnt <= '0;
                            cyc_cnt  <= '0;
                            busy     <= 1'b1;
                            state    <= StRise;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                StRise, StFall: begin
                    if (period_tick) begin
                        compare <= level;
                    end
                    if (stop) begin
                        state <= StDrain;
                    end else if (period_tick) begin
                        if (hold_hit) begin
                            hold_cnt <= '0;
                            if (state == StRise) begin
                                // Turn around only once a step is taken while already at hi
                                if (level == hi_q) begin
                                    state <= StFall;
                                end else begin
                                    level <= level_up;
                                end
                            end else begin
                                // Reaching lo on a step closes one lo->hi->lo cycle
                                if (level == lo_q) begin
                                    cyc_cnt <= cyc_next;
                                    state   <= last_cycle ? StDrain : StRise;
                                end else begin
                                    level <= level_dn;
                                end
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (period_tick) begin
                        compare <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    pwm_fade_ctrl_pwm #(
        .CTR_LEN (CTR_LEN)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .compare (compare),
        .pwm     (pwm)
    );

endmodule
